// File: rtl/piso_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in/serial-out shift register slice.
//   state_t  : FSM state encoding (IDLE waits for a word, SHIFT streams it out)
//   DIR_LSB  : bit-order code for least-significant bit first
//   DIR_MSB  : bit-order code for most-significant bit first
// ----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/piso_shift_reg_if.sv
// ----------------------------------------------------------------------------
// piso_shift_reg_if
// Bundles the load handshake and the serial output side of piso_shift_reg.
//   load_valid / load_ready / load_data / dir : word load handshake
//   shift_en                                  : downstream consumes sout
//   sout / sout_valid                         : serial bit stream
//   done / busy                               : completion pulse and status
// Modports:
//   master : the upstream/downstream environment driving the block
//   slave  : the shift register itself
// ----------------------------------------------------------------------------
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
);
    import piso_pkg::*;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             dir;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             done;
    logic             busy;

    modport master (
        output load_valid, load_data, dir, shift_en,
        input  load_ready, sout, sout_valid, done, busy
    );

    modport slave (
        input  load_valid, load_data, dir, shift_en,
        output load_ready, sout, sout_valid, done, busy
    );

endinterface

// File: rtl/piso_shift_reg_bit_counter.sv
// ----------------------------------------------------------------------------
// bit_counter
// Loadable down-counter tracking how many bits of the current word remain.
//   clk, rst    : clock and synchronous active-high reset (count -> 0)
//   load        : load load_value (takes priority over dec)
//   load_value  : value loaded on load
//   dec         : decrement by one; saturates at zero
//   count       : current count
//   last        : count == 1, i.e. the bit on the output is the final one
// ----------------------------------------------------------------------------
module bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    import piso_pkg::*;

    // Zero is guarded so a stray decrement can never wrap the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/piso_shift_reg.sv
// ----------------------------------------------------------------------------
// piso_shift_reg
// Serialises a WIDTH-bit word into a one-bit stream for a downstream D
// flip-flop stage. A word is accepted by a valid/ready handshake while IDLE,
// streamed LSB- or MSB-first while SHIFT under shift_en, and completion is
// marked by a one-cycle done pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : piso_shift_reg_if slave modport (handshake, serial out, status)
// ----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    piso_shift_reg_if.slave   bus
);
    import piso_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic               dir_q;
    logic               done_q;
    logic [CNT_W-1:0]   count;
    logic               last;
    logic               handshake;
    logic               consume;

    // load_ready is gated by rst so a word offered during reset is never taken.
    assign bus.load_ready = (state == IDLE) && !rst;
    assign handshake      = bus.load_valid && bus.load_ready;
    assign consume        = (state == SHIFT) && bus.shift_en;

    bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (handshake),
        .load_value (CNT_W'(WIDTH)),
        .dec        (consume),
        .count      (count),
        .last       (last)
    );

    // FSM, shift register and latched bit order. The register always shifts
    // toward the output end selected at load time and back-fills with zero,
    // so it is all zeros by the time the word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            dir_q  <= DIR_LSB;
            done_q <= 1'b0;
        end else begin
            done_q <= consume && last;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        sreg  <= bus.load_data;
                        dir_q <= bus.dir;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.shift_en) begin
                        if (dir_q == DIR_MSB) begin
                            sreg <= {sreg[WIDTH-2:0], 1'b0};
                        end else begin
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                        end
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sout_valid = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.done       = done_q;
    assign bus.sout       = (state == SHIFT) ?
                            ((dir_q == DIR_MSB) ? sreg[WIDTH-1] : sreg[0]) : 1'b0;

endmodule

// File: tb/tb_piso_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_piso_shift_reg
// Scoreboard bench for piso_shift_reg. The stimulus thread loads words and,
// at each accepted handshake, pushes the expected bit sequence (computed
// directly from the word and its bit order) into a queue. A monitor thread
// samples on the falling edge and compares the serial stream, done pulse and
// status outputs against that queue.
// ----------------------------------------------------------------------------
module tb_piso_shift_reg;
    import piso_pkg::*;

    localparam int WIDTH = 8;
    localparam int WAIT_LIMIT = 300;

    typedef struct packed {
        logic bit_val;
        logic last_bit;
    } exp_bit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    piso_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    piso_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_bit_t exp_q[$];
    logic     pending_done = 1'b0;
    int       compared     = 0;
    int       mismatched   = 0;
    int       stall_pct    = 0;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Advance one clock and pick a new shift_en away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.shift_en = ($urandom_range(0, 99) >= stall_pct);
    endtask

    // Wait for the model to go idle, then offer one word for exactly one edge
    // (or keep load_valid high afterwards with scrambled data when hold_valid).
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic dir_in,
                                 input logic hold_valid);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL word_drain_timeout: %0d bits still pending, expected 0", exp_q.size());
            exp_q.delete();
            pending_done = 1'b0;
        end
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.dir        = dir_in;
        tick();
        for (int i = 0; i < WIDTH; i++) begin
            exp_bit_t e;
            e.bit_val  = dir_in ? data[WIDTH-1-i] : data[i];
            e.last_bit = (i == WIDTH - 1);
            exp_q.push_back(e);
        end
        bus.load_valid = hold_valid;
        bus.load_data  = WIDTH'($urandom);
        bus.dir        = 1'($urandom);
    endtask

    // Monitor: compare outputs against the scoreboard every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                logic has_word;
                has_word = (exp_q.size() != 0);
                checkOutput("done", 32'(bus.done), 32'(pending_done));
                checkOutput("sout_valid", 32'(bus.sout_valid), 32'(has_word));
                checkOutput("busy", 32'(bus.busy), 32'(has_word));
                checkOutput("load_ready", 32'(bus.load_ready), 32'(!has_word));
                if (has_word) begin
                    checkOutput("sout", 32'(bus.sout), 32'(exp_q[0].bit_val));
                    if (bus.shift_en) begin
                        exp_bit_t e;
                        e = exp_q.pop_front();
                        pending_done = e.last_bit;
                    end else begin
                        pending_done = 1'b0;
                    end
                end else begin
                    checkOutput("sout_idle", 32'(bus.sout), 32'd0);
                    pending_done = 1'b0;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        int n;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAA;
        bus.dir        = DIR_LSB;
        bus.shift_en   = 1'b1;
        rst            = 1'b1;

        // Reset held two edges with load_valid high: nothing captured.
        tick();
        tick();
        checkOutput("rst_load_ready", 32'(bus.load_ready), 32'd0);
        checkOutput("rst_sout", 32'(bus.sout), 32'd0);
        checkOutput("rst_sout_valid", 32'(bus.sout_valid), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        rst            = 1'b0;
        bus.load_valid = 1'b0;
        #1;
        checkOutput("post_rst_load_ready", 32'(bus.load_ready), 32'd1);

        // Plain LSB- and MSB-first words, then a stalled word.
        stall_pct = 0;
        applyStimulus(8'h1E, DIR_LSB, 1'b0);
        applyStimulus(8'h1E, DIR_MSB, 1'b0);
        stall_pct = 40;
        applyStimulus(8'hA5, DIR_LSB, 1'b0);

        // Back-to-back with load_valid held through the first word.
        stall_pct = 0;
        applyStimulus(8'hFF, DIR_LSB, 1'b1);
        applyStimulus(8'h00, DIR_MSB, 1'b0);

        // Reset after three bits of a word: abort, no done pulse.
        applyStimulus(8'hF0, DIR_LSB, 1'b0);
        bus.shift_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            bus.shift_en = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        pending_done = 1'b0;
        tick();
        rst = 1'b0;
        applyStimulus(8'h01, DIR_LSB, 1'b0);

        // Randomized words, bit orders, stall rates and held valids.
        for (int w = 0; w < 30; w++) begin
            stall_pct = $urandom_range(0, 50);
            applyStimulus(WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        // Drain the final word and let the done pulse be checked.
        bus.load_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL final_drain_timeout: %0d bits still pending, expected 0", exp_q.size());
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in/serial-out shift register that serialises a WIDTH-bit word into a one-bit stream for the single-bit D flip-flop stage downstream; `sout` drives that stage's `d` input directly. A word is accepted through a valid/ready load handshake, shifted out LSB- or MSB-first under an advance enable, and completion is flagged with a one-cycle `done` pulse. Built as a small two-state FSM, a bit counter, and a shift register.

## Interface
- `WIDTH`, default 8, word width in bits, minimum 2.
- `CNT_W`, default $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_valid`  in  1  upstream offers `load_data`.
- `load_ready`  out  1  block can accept a word; high only in IDLE and low while `rst` is high.
- `load_data`  in  WIDTH  word to serialise; sampled on a handshake.
- `dir`  in  1  bit order, sampled with `load_data`: 0 = LSB first, 1 = MSB first.
- `shift_en`  in  1  downstream consumes the current `sout` bit this cycle.
- `sout`  out  1  current serial bit; 0 when not valid.
- `sout_valid`  out  1  `sout` holds a live bit (high in SHIFT).
- `done`  out  1  one-cycle pulse after the last bit is consumed.
- `busy`  out  1  equal to state == SHIFT.

## Operation
- States: IDLE, SHIFT. Reset → IDLE.
- IDLE:
  - `load_ready`=1.
  - On `load_valid`&&`load_ready`: shift register ← `load_data`, latched dir ← `dir`, counter ← WIDTH, next state SHIFT.
  - `shift_en` is ignored.
- SHIFT:
  - `sout` = sreg[0] when dir=0, sreg[WIDTH-1] when dir=1.
  - On `shift_en`=1: shift toward the output end, fill the vacated bit with 0, decrement the counter.
  - When `shift_en`=1 and counter==1: next state IDLE and `done` registered high for the following cycle.
  - On `shift_en`=0: everything holds; stalls may last indefinitely.
- `load_valid` in SHIFT is ignored (`load_ready`=0); the word is not captured.
- `dir` and `load_data` changes after the handshake have no effect on the word in flight.
- Counter never underflows; counter==0 only occurs in IDLE.

## Timing
- Reset values, after the first edge with `rst`=1:
  - `load_ready`=1 once `rst` deasserts.
  - `sout`=0, `sout_valid`=0, `done`=0, `busy`=0.
  - Shift register = 0, counter = 0.
- Load latency: handshake at edge N; `sout_valid`=1 and the first bit on `sout` from cycle N+1.
- Each edge with `shift_en`=1 in SHIFT presents the next bit in the cycle after that edge.
- Minimum word time is WIDTH cycles in SHIFT. The last consuming edge is at N+WIDTH with no stalls.
- After the last consuming edge: `done`=1, `sout_valid`=0, `load_ready`=1, all in the same cycle. The next word can be accepted in that cycle, giving a 1-cycle gap between words.
- `rst` mid-word: abort at that edge, no `done` pulse, drop to IDLE with reset values.
- `rst` dominates a simultaneous handshake: the word is not captured.

## Structure
- Shared package `piso_pkg`: state enum (IDLE, SHIFT) and the localparams for direction encoding (DIR_LSB=0, DIR_MSB=1).
- One sub-module, `bit_counter`: loadable down-counter with load, decrement enable, and a `last` output (count==1); parameterised by CNT_W.
- Top level holds the FSM, the shift register, the latched dir, and the `done` flop.

## Test plan
- Reset: hold `rst` 2 cycles with `load_valid`=1 → no capture. Outputs 0 except `load_ready`, which goes to 1 after release.
- LSB first: load 8'h1E with dir=0 and `shift_en` tied 1 → `sout` over 8 cycles is 0,1,1,1,1,0,0,0. `done` pulses in cycle 9 together with `load_ready`=1.
- MSB first: load 8'h1E with dir=1 → `sout` is 0,0,0,1,1,1,1,0. Toggling `dir` mid-word changes nothing.
- Stalls: load 8'hA5 with dir=0 and `shift_en` low on bits 2 and 5 for 3 cycles each → `sout` holds during each stall. Bit sequence is still 1,0,1,0,0,1,0,1, and `done` arrives 6 cycles later than the no-stall case.
- Back-to-back: `load_valid` held high with words 8'hFF then 8'h00 → second word captured in the `done` cycle. `sout_valid` low for exactly 1 cycle between words. While the first word is in SHIFT, `load_valid` is ignored.
- Reset mid-word: assert `rst` after 3 bits of 8'hF0 → next cycle `sout_valid`=0, `done` never pulses. A new load of 8'h01 then shifts out 1,0,0,0,0,0,0,0.
